cascade_sched: RTL

Window scheduler for the Haar-cascade face-detection pipeline. After the integral image is built, it steps a fixed-size detection window across the image and issues the 36 classifier stage cores one at a time for each window position. A window is abandoned at its first failing stage. A window that passes all stages is forwarded to the bounding-box block over a valid/ready handshake.

---
 rtl/cascade_sched_pkg.sv | 46 ++++
 rtl/cascade_sched_win_stepper.sv | 84 ++++++++
 rtl/cascade_sched.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cascade_sched_pkg.sv
// ---------------------------------------------------------------------------
// cascade_sched_pkg
// Shared definitions for the Haar-cascade window scheduler and its neighbours
// (integral-image summer, bounding-box block). It holds the default window
// geometry, the classifier stage count and the 3-bit scheduler state encoding,
// so that every block agrees on the same window size and stride.
// ---------------------------------------------------------------------------
package cascade_sched_pkg;

    localparam int unsigned NUM_STAGES = 36;   // classifier stage cores
    localparam int unsigned IDX_W      = 6;    // width of stage index
    localparam int unsigned WIN        = 24;   // window edge in pixels
    localparam int unsigned STEP       = 1;    // stride in x and y

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } sched_state_e;

    // True when a window placed at origin+adv still lies inside limit.
    // The sum is widened beyond 32 bits so images close to 2^32 pixels wide
    // cannot wrap the comparison.
    function automatic logic win_fits(input logic [31:0] origin,
                                      input logic [31:0] adv,
                                      input logic [31:0] win,
                                      input logic [31:0] limit);
        logic [33:0] end_pos;
        end_pos  = {2'b00, origin} + {2'b00, adv} + {2'b00, win};
        win_fits = (end_pos <= {2'b00, limit});
    endfunction

    // Saturating 16-bit increment for the detection counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            sat_inc16 = val;
        end else begin
            sat_inc16 = val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/cascade_sched_win_stepper.sv
// ---------------------------------------------------------------------------
// win_stepper
// Holds the current detection-window origin and performs the raster advance
// (x fastest, stride STEP_P). It also flags when the next advance would push
// the window past the bottom of the image, which ends the scan.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        return origin to (0,0)
//   advance_i      move to the next raster position
//   width_i        latched image width
//   height_i       latched image height
//   x_o, y_o       current window origin (registered)
//   scan_end_o     advancing from the current origin ends the scan
// ---------------------------------------------------------------------------
module win_stepper
    import cascade_sched_pkg::*;
#(
    parameter int unsigned WIN_P  = WIN,
    parameter int unsigned STEP_P = STEP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        advance_i,
    input  logic [31:0] width_i,
    input  logic [31:0] height_i,
    output logic [31:0] x_o,
    output logic [31:0] y_o,
    output logic        scan_end_o
);

    localparam logic [31:0] WIN_W  = 32'(WIN_P);
    localparam logic [31:0] STEP_W = 32'(STEP_P);

    logic [31:0] x_q;
    logic [31:0] x_d;
    logic [31:0] y_q;
    logic [31:0] y_d;
    logic        wrap_s;
    logic        scan_end_s;

    // Row wrap when the next x no longer fits; scan ends when the wrapped
    // row would also fall off the bottom edge.
    assign wrap_s     = !win_fits(x_q, STEP_W, WIN_W, width_i);
    assign scan_end_s = wrap_s && !win_fits(y_q, STEP_W, WIN_W, height_i);

    // Next-origin selection: clear, raster advance or hold.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = 32'd0;
            y_d = 32'd0;
        end else if (advance_i) begin
            if (wrap_s) begin
                x_d = 32'd0;
                y_d = y_q + STEP_W;
            end else begin
                x_d = x_q + STEP_W;
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Origin registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= 32'd0;
            y_q <= 32'd0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o        = x_q;
    assign y_o        = y_q;
    assign scan_end_o = scan_end_s;

endmodule

// File: rtl/cascade_sched.sv
// ---------------------------------------------------------------------------
// cascade_sched
// Window scheduler for the Haar-cascade face detector. Once the integral
// image is ready it walks a WIN_P x WIN_P window over the image in raster
// order, issues the classifier stages one at a time per window, abandons a
// window at its first failing stage, and hands every fully passing window to
// the bounding-box block over a valid/ready handshake.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   width_i, height_i      image size, captured with start_i
//   start_i                integral image ready (one-cycle pulse)
//   stage_start_o          evaluate stage_idx_o on the current window
//   stage_idx_o            stage being issued
//   win_x_o, win_y_o       current window origin
//   stage_done_i           stage result valid
//   stage_pass_i           stage result, qualified by stage_done_i
//   det_valid_o            detection pending
//   det_x_o, det_y_o       detection origin, stable while det_valid_o
//   det_ready_i            bounding-box block accepts the detection
//   busy_o                 scan in progress (LOAD through DONE)
//   done_o                 scan complete (one-cycle pulse)
//   det_count_o            detections this scan, saturating
// ---------------------------------------------------------------------------
module cascade_sched
    import cascade_sched_pkg::*;
#(
    parameter int unsigned NUM_STAGES_P = NUM_STAGES,
    parameter int unsigned WIN_P        = WIN,
    parameter int unsigned STEP_P       = STEP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] width_i,
    input  logic [31:0] height_i,
    input  logic        start_i,
    output logic        stage_start_o,
    output logic [5:0]  stage_idx_o,
    output logic [31:0] win_x_o,
    output logic [31:0] win_y_o,
    input  logic        stage_done_i,
    input  logic        stage_pass_i,
    output logic        det_valid_o,
    output logic [31:0] det_x_o,
    output logic [31:0] det_y_o,
    input  logic        det_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] det_count_o
);

    localparam logic [5:0]  LAST_STAGE = 6'(NUM_STAGES_P - 1);
    localparam logic [31:0] WIN_W      = 32'(WIN_P);

    sched_state_e state_q;
    logic [31:0]  width_q;
    logic [31:0]  height_q;
    logic [5:0]   stage_idx_q;
    logic         stage_start_q;
    logic         det_valid_q;
    logic [31:0]  det_x_q;
    logic [31:0]  det_y_q;
    logic         busy_q;
    logic         done_q;
    logic [15:0]  det_count_q;

    logic         step_clear_s;
    logic         step_advance_s;
    logic [31:0]  win_x_s;
    logic [31:0]  win_y_s;
    logic         scan_end_s;

    // The stepper moves exactly once per NEXT and is cleared in LOAD.
    assign step_clear_s   = (state_q == ST_LOAD);
    assign step_advance_s = (state_q == ST_NEXT);

    win_stepper #(
        .WIN_P  (WIN_P),
        .STEP_P (STEP_P)
    ) u_win_stepper (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (step_clear_s),
        .advance_i  (step_advance_s),
        .width_i    (width_q),
        .height_i   (height_q),
        .x_o        (win_x_s),
        .y_o        (win_y_s),
        .scan_end_o (scan_end_s)
    );

    // Scheduler FSM. Pulse outputs (stage_start, done) are set on the
    // transition into their state so they are registered and last one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            width_q       <= 32'd0;
            height_q      <= 32'd0;
            stage_idx_q   <= 6'd0;
            stage_start_q <= 1'b0;
            det_valid_q   <= 1'b0;
            det_x_q       <= 32'd0;
            det_y_q       <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            det_count_q   <= 16'd0;
        end else begin
            stage_start_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        width_q  <= width_i;
                        height_q <= height_i;
                        busy_q   <= 1'b1;
                        state_q  <= ST_LOAD;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end

                ST_LOAD: begin
                    stage_idx_q <= 6'd0;
                    det_count_q <= 16'd0;
                    if ((width_q < WIN_W) || (height_q < WIN_W)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        stage_start_q <= 1'b1;
                        state_q       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (stage_done_i) begin
                        if (!stage_pass_i) begin
                            state_q <= ST_NEXT;
                        end else if (stage_idx_q != LAST_STAGE) begin
                            stage_idx_q   <= stage_idx_q + 6'd1;
                            stage_start_q <= 1'b1;
                            state_q       <= ST_ISSUE;
                        end else begin
                            det_valid_q <= 1'b1;
                            det_x_q     <= win_x_s;
                            det_y_q     <= win_y_s;
                            state_q     <= ST_EMIT;
                        end
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end

                ST_EMIT: begin
                    if (det_ready_i) begin
                        det_valid_q <= 1'b0;
                        det_count_q <= sat_inc16(det_count_q);
                        state_q     <= ST_NEXT;
                    end else begin
                        state_q     <= ST_EMIT;
                    end
                end

                ST_NEXT: begin
                    stage_idx_q <= 6'd0;
                    if (scan_end_s) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        stage_start_q <= 1'b1;
                        state_q       <= ST_ISSUE;
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    det_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign stage_start_o = stage_start_q;
    assign stage_idx_o   = stage_idx_q;
    assign win_x_o       = win_x_s;
    assign win_y_o       = win_y_s;
    assign det_valid_o   = det_valid_q;
    assign det_x_o       = det_x_q;
    assign det_y_o       = det_y_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign det_count_o   = det_count_q;

endmodule
